// File: rtl/md_unit.sv
// Iterative signed multiply/divide: result writeback pulses 32 cycles after the start edge.
// No flow control; stall holds the pipeline from the start cycle through RUN and drops in DONE.
module md_unit #(
  parameter int               WIDTH        = 32,
  parameter int               ITER         = 32,
  parameter logic [4:0]       RSTATUS_REG  = 5'd30,
  parameter logic [WIDTH-1:0] MUL_EXC_CODE = 32'd4,
  parameter logic [WIDTH-1:0] DIV_EXC_CODE = 32'd5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       in_rd,
  output logic             stall,
  output logic             data_resultRDY,
  output logic             md_writeEnable,
  output logic [4:0]       md_writeReg,
  output logic [WIDTH-1:0] md_result,
  output logic             md_exception
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic               start, last;
  logic [CNT_W-1:0]   cnt;
  logic               op_div, neg, div_exc, exc_q;
  logic [4:0]         rd_q;
  logic [WIDTH-1:0]   opnd, res_q;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod_s;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge, mul_ovf;

  assign start  = ctrl_MULT | ctrl_DIV;
  assign last   = (cnt == CNT_W'(ITER - 1));
  assign sign_a = data_operandA[WIDTH-1];
  assign sign_b = data_operandB[WIDTH-1];
  assign a_mag  = sign_a ? -data_operandA : data_operandA;
  assign b_mag  = sign_b ? -data_operandB : data_operandB;

  // acc doubles as {hi, lo} for shift-add and {remainder, quotient} for restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[WIDTH-1:0] - opnd;
    if (op_div)
      acc_nxt = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    else
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

  // Low half of the negated accumulator is also the signed quotient
  assign prod_s  = neg ? -acc_nxt : acc_nxt;
  assign mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      op_div  <= 1'b0;
      neg     <= 1'b0;
      div_exc <= 1'b0;
      exc_q   <= 1'b0;
      rd_q    <= '0;
      opnd    <= '0;
      res_q   <= '0;
      acc     <= '0;
    end else if (state == IDLE && start) begin
      cnt     <= '0;
      op_div  <= !ctrl_MULT;
      neg     <= sign_a ^ sign_b;
      rd_q    <= in_rd;
      opnd    <= ctrl_MULT ? a_mag : b_mag;
      acc     <= {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
      div_exc <= (data_operandB == '0) ||
                 (data_operandA == MIN_NEG && data_operandB == {WIDTH{1'b1}});
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nxt;
      if (last) begin
        res_q <= prod_s[WIDTH-1:0];
        exc_q <= op_div ? div_exc : mul_ovf;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    stall          = 1'b0;
    data_resultRDY = 1'b0;
    md_writeEnable = 1'b0;
    md_writeReg    = '0;
    md_result      = '0;
    md_exception   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        md_exception   = exc_q;
        if (exc_q) begin
          md_writeReg    = RSTATUS_REG;
          md_result      = op_div ? DIV_EXC_CODE : MUL_EXC_CODE;
          md_writeEnable = 1'b1;
        end else begin
          md_writeReg    = rd_q;
          md_result      = res_q;
          md_writeEnable = (rd_q != 5'd0);
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: signed mul/div results, exceptions, stall window, reset and start handling.
module tb_md_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [4:0]  in_rd;
  logic        stall, data_resultRDY, md_writeEnable, md_exception;
  logic [4:0]  md_writeReg;
  logic [31:0] md_result;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          got_lat, got_stall;
  logic        got_we, got_exc;
  logic [4:0]  got_reg;
  logic [31:0] got_res;

  md_unit dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .in_rd(in_rd),
    .stall(stall), .data_resultRDY(data_resultRDY), .md_writeEnable(md_writeEnable),
    .md_writeReg(md_writeReg), .md_result(md_result), .md_exception(md_exception)
  );

  always #5 clock = ~clock;

  // Drives one op from the current cycle, scrambles operands after the start edge, waits for RDY.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int pulse_at);
    got_lat = -1; got_stall = 0; got_we = 1'bx; got_exc = 1'bx; got_reg = 'x; got_res = 'x;
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b; in_rd = rd;
    #1;
    if (stall) got_stall++;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (n == 0) begin
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = ~a; data_operandB = a ^ b; in_rd = ~rd;
      end
      if (pulse_at > 0 && n == pulse_at) ctrl_DIV = 1'b1;
      if (pulse_at > 0 && n == pulse_at + 1) ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        got_lat = n; got_we = md_writeEnable; got_exc = md_exception;
        got_reg = md_writeReg; got_res = md_result;
        break;
      end
      if (stall) got_stall++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = 0; data_operandB = 0; in_rd = 0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b want 0", stall); end
    n_cmp++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset rdy: got %b want 0", data_resultRDY); end
    n_cmp++; if (md_writeEnable !== 1'b0) begin n_fail++; $display("FAIL reset we: got %b want 0", md_writeEnable); end
    n_cmp++; if (md_exception !== 1'b0) begin n_fail++; $display("FAIL reset exc: got %b want 0", md_exception); end
    n_cmp++; if (md_writeReg !== 5'd0) begin n_fail++; $display("FAIL reset reg: got %0d want 0", md_writeReg); end
    n_cmp++; if (md_result !== 32'd0) begin n_fail++; $display("FAIL reset result: got %h want 0", md_result); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_mul;
    run_op(1, 0, 32'd7, 32'hFFFFFFFA, 5'd5, 0);
    n_cmp++; if (got_lat !== 32) begin n_fail++; $display("FAIL mul latency: got %0d want 32", got_lat); end
    n_cmp++; if (got_stall !== 33) begin n_fail++; $display("FAIL mul stall cycles: got %0d want 33", got_stall); end
    n_cmp++; if (got_reg !== 5'd5) begin n_fail++; $display("FAIL mul reg: got %0d want 5", got_reg); end
    n_cmp++; if (got_res !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL mul result: got %h want ffffffd6", got_res); end
    n_cmp++; if (got_exc !== 1'b0) begin n_fail++; $display("FAIL mul exc: got %b want 0", got_exc); end
    n_cmp++; if (got_we !== 1'b1) begin n_fail++; $display("FAIL mul we: got %b want 1", got_we); end
    @(posedge clock); #1;
    n_cmp++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL rdy one cycle: got %b want 0", data_resultRDY); end
    n_cmp++; if (md_result !== 32'd0) begin n_fail++; $display("FAIL result outside done: got %h want 0", md_result); end
    run_op(1, 0, 32'h80000000, 32'd1, 5'd10, 0);
    n_cmp++; if (got_res !== 32'h80000000) begin n_fail++; $display("FAIL mul min result: got %h want 80000000", got_res); end
    n_cmp++; if (got_exc !== 1'b0) begin n_fail++; $display("FAIL mul min exc: got %b want 0", got_exc); end
    @(posedge clock); #1;
  endtask

  task automatic test_mul_overflow;
    run_op(1, 0, 32'h00010000, 32'h00010000, 5'd3, 0);
    n_cmp++; if (got_exc !== 1'b1) begin n_fail++; $display("FAIL mulovf exc: got %b want 1", got_exc); end
    n_cmp++; if (got_reg !== 5'd30) begin n_fail++; $display("FAIL mulovf reg: got %0d want 30", got_reg); end
    n_cmp++; if (got_res !== 32'd4) begin n_fail++; $display("FAIL mulovf result: got %h want 4", got_res); end
    n_cmp++; if (got_we !== 1'b1) begin n_fail++; $display("FAIL mulovf we: got %b want 1", got_we); end
    @(posedge clock); #1;
    run_op(1, 0, 32'h80000000, 32'hFFFFFFFF, 5'd3, 0);
    n_cmp++; if (got_res !== 32'd4) begin n_fail++; $display("FAIL mulovf min result: got %h want 4", got_res); end
    @(posedge clock); #1;
  endtask

  task automatic test_div;
    run_op(0, 1, 32'hFFFFFFF9, 32'd2, 5'd8, 0);
    n_cmp++; if (got_res !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div result: got %h want fffffffd", got_res); end
    n_cmp++; if (got_reg !== 5'd8) begin n_fail++; $display("FAIL div reg: got %0d want 8", got_reg); end
    n_cmp++; if (got_exc !== 1'b0) begin n_fail++; $display("FAIL div exc: got %b want 0", got_exc); end
    @(posedge clock); #1;
    run_op(0, 1, 32'hFFFFFFF4, 32'hFFFFFFFC, 5'd11, 0);
    n_cmp++; if (got_res !== 32'd3) begin n_fail++; $display("FAIL div negneg result: got %h want 3", got_res); end
    @(posedge clock); #1;
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 5'd9, 0);
    n_cmp++; if (got_reg !== 5'd30) begin n_fail++; $display("FAIL divovf reg: got %0d want 30", got_reg); end
    n_cmp++; if (got_res !== 32'd5) begin n_fail++; $display("FAIL divovf result: got %h want 5", got_res); end
    n_cmp++; if (got_exc !== 1'b1) begin n_fail++; $display("FAIL divovf exc: got %b want 1", got_exc); end
    @(posedge clock); #1;
  endtask

  task automatic test_div_zero_rd0;
    run_op(0, 1, 32'd100, 32'd0, 5'd4, 0);
    n_cmp++; if (got_lat !== 32) begin n_fail++; $display("FAIL divzero latency: got %0d want 32", got_lat); end
    n_cmp++; if (got_reg !== 5'd30) begin n_fail++; $display("FAIL divzero reg: got %0d want 30", got_reg); end
    n_cmp++; if (got_res !== 32'd5) begin n_fail++; $display("FAIL divzero result: got %h want 5", got_res); end
    n_cmp++; if (got_exc !== 1'b1) begin n_fail++; $display("FAIL divzero exc: got %b want 1", got_exc); end
    @(posedge clock); #1;
    run_op(1, 0, 32'd9, 32'd9, 5'd0, 0);
    n_cmp++; if (got_we !== 1'b0) begin n_fail++; $display("FAIL rd0 we: got %b want 0", got_we); end
    n_cmp++; if (got_res !== 32'd81) begin n_fail++; $display("FAIL rd0 result: got %h want 51", got_res); end
    n_cmp++; if (got_exc !== 1'b0) begin n_fail++; $display("FAIL rd0 exc: got %b want 0", got_exc); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    ctrl_MULT = 1; data_operandA = 32'd5; data_operandB = 32'd5; in_rd = 5'd2;
    @(posedge clock); #1;
    ctrl_MULT = 0;
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midreset stall: got %b want 0", stall); end
    n_cmp++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL midreset rdy: got %b want 0", data_resultRDY); end
    n_cmp++; if (md_result !== 32'd0) begin n_fail++; $display("FAIL midreset result: got %h want 0", md_result); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (data_resultRDY || stall) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset activity: got %0d cycles want 0", pulses); end
    run_op(1, 0, 32'd3, 32'd4, 5'd7, 0);
    n_cmp++; if (got_res !== 32'd12) begin n_fail++; $display("FAIL postreset result: got %h want c", got_res); end
    n_cmp++; if (got_lat !== 32) begin n_fail++; $display("FAIL postreset latency: got %0d want 32", got_lat); end
    @(posedge clock); #1;
  endtask

  task automatic test_both_starts;
    run_op(1, 1, 32'd6, 32'd3, 5'd12, 0);
    n_cmp++; if (got_res !== 32'd18) begin n_fail++; $display("FAIL both starts result: got %h want 12", got_res); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    run_op(1, 0, 32'd2, 32'd3, 5'd6, 5);
    n_cmp++; if (got_res !== 32'd6) begin n_fail++; $display("FAIL run pulse result: got %h want 6", got_res); end
    n_cmp++; if (got_lat !== 32) begin n_fail++; $display("FAIL run pulse latency: got %0d want 32", got_lat); end
    ctrl_MULT = 1; data_operandA = 32'd4; data_operandB = 32'd5; in_rd = 5'd13;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL done stall: got %b want 0", stall); end
    @(posedge clock); #1;
    ctrl_MULT = 0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL done start ignored: got stall %b want 0", stall); end
    run_op(1, 0, 32'hFFFFFFFD, 32'd5, 5'd14, 0);
    n_cmp++; if (got_res !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL b2b result: got %h want fffffff1", got_res); end
    n_cmp++; if (got_lat !== 32) begin n_fail++; $display("FAIL b2b latency: got %0d want 32", got_lat); end
    n_cmp++; if (got_reg !== 5'd14) begin n_fail++; $display("FAIL b2b reg: got %0d want 14", got_reg); end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset;
    test_mul;
    test_mul_overflow;
    test_div;
    test_div_zero_rd0;
    test_reset_mid_run;
    test_both_starts;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
